// File: rtl/seg_scan_decoder.sv
// Readback of the multiplexed 7-segment bus: recovers per-anode BCD digits and dp into frames.
// Optional SEG_DECODE_ERR_CNT_EN adds a saturating count of undecodable captures.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0]  DIGIT_MASK     = 8'hFC
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  an,
  input  logic [7:0]  seg,
  output logic [31:0] digits_out,
  output logic [7:0]  dp_out,
  output logic        frame_valid,
  output logic        stale,
  output logic        seg_err,
  output logic [7:0]  err_count
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StLocked} state_e;

  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 4'd0;
      7'h79:   decode = 4'd1;
      7'h24:   decode = 4'd2;
      7'h30:   decode = 4'd3;
      7'h19:   decode = 4'd4;
      7'h12:   decode = 4'd5;
      7'h02:   decode = 4'd6;
      7'h78:   decode = 4'd7;
      7'h00:   decode = 4'd8;
      7'h10:   decode = 4'd9;
      default: decode = 4'hF;
    endcase
  endfunction

  function automatic logic [2:0] low_index(input logic [7:0] an_l);
    low_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_l[i]) low_index = 3'(i);
    end
  endfunction

  logic [7:0]    an_meta_q, an_sync_q, an_smp_q;
  logic [7:0]    seg_meta_q, seg_sync_q, seg_smp_q;
  state_e        state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [7:0]    cand_an_q, cand_an_d, cand_seg_q, cand_seg_d;
  logic [31:0]   digit_sh_q, digit_sh_d, digits_q, digits_d;
  logic [7:0]    dp_sh_q, dp_sh_d, dp_q, dp_d;
  logic [7:0]    seen_q, seen_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          frame_valid_q, frame_valid_d, stale_q, stale_d, seg_err_q, seg_err_d;

  logic       smp_valid, smp_blank, capture, frame_done, timeout_hit;
  logic [2:0] cap_idx;
  logic [3:0] cap_nib;

  assign smp_valid   = $onehot(~an_smp_q);
  assign smp_blank   = (seg_smp_q[6:0] == 7'h7F);
  assign cap_idx     = low_index(cand_an_q);
  assign cap_nib     = decode(cand_seg_q[6:0]);
  assign frame_done  = ((seen_q & DIGIT_MASK) == DIGIT_MASK);
  assign timeout_hit = !capture && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    cand_an_d  = cand_an_q;
    cand_seg_d = cand_seg_q;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (smp_valid && !smp_blank) begin
          state_d    = StSettle;
          stab_d     = SW'(1);
          cand_an_d  = an_smp_q;
          cand_seg_d = seg_smp_q;
        end
      end
      StSettle: begin
        if (!smp_valid) begin
          state_d = StIdle;
          stab_d  = '0;
        end else if (smp_blank) begin
          // PWM off phase: neither counts nor breaks stability
          stab_d = stab_q;
        end else if (an_smp_q == cand_an_q && seg_smp_q == cand_seg_q) begin
          if (stab_q == SW'(STABLE_CYCLES - 1)) begin
            capture = 1'b1;
            state_d = StLocked;
            stab_d  = SW'(STABLE_CYCLES);
          end else begin
            stab_d = stab_q + SW'(1);
          end
        end else begin
          cand_an_d  = an_smp_q;
          cand_seg_d = seg_smp_q;
          stab_d     = SW'(1);
        end
      end
      StLocked: begin
        if (!smp_valid) begin
          state_d = StIdle;
          stab_d  = '0;
        end else if (an_smp_q != cand_an_q) begin
          state_d    = StSettle;
          cand_an_d  = an_smp_q;
          cand_seg_d = seg_smp_q;
          stab_d     = smp_blank ? SW'(0) : SW'(1);
        end else if (!smp_blank && seg_smp_q != cand_seg_q) begin
          state_d    = StSettle;
          cand_seg_d = seg_smp_q;
          stab_d     = SW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        stab_d  = '0;
      end
    endcase
  end

  always_comb begin
    digit_sh_d    = digit_sh_q;
    dp_sh_d       = dp_sh_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    dp_d          = dp_q;
    frame_valid_d = frame_done;
    stale_d       = stale_q;
    seg_err_d     = capture && (cap_nib == 4'hF);
    to_cnt_d      = to_cnt_q;

    if (frame_done) begin
      digits_d = digit_sh_q;
      dp_d     = dp_sh_q;
      stale_d  = 1'b0;
      seen_d   = '0;
    end
    if (timeout_hit) begin
      stale_d = 1'b1;
      seen_d  = '0;
    end
    if (capture) begin
      digit_sh_d[{cap_idx, 2'b00} +: 4] = cap_nib;
      dp_sh_d[cap_idx]                  = ~cand_seg_q[7];
      seen_d[cap_idx]                   = 1'b1;
      to_cnt_d                          = '0;
    end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an_meta_q     <= 8'hFF;
      an_sync_q     <= 8'hFF;
      an_smp_q      <= 8'hFF;
      seg_meta_q    <= 8'hFF;
      seg_sync_q    <= 8'hFF;
      seg_smp_q     <= 8'hFF;
      state_q       <= StIdle;
      stab_q        <= '0;
      cand_an_q     <= 8'hFF;
      cand_seg_q    <= 8'hFF;
      digit_sh_q    <= '0;
      dp_sh_q       <= '0;
      seen_q        <= '0;
      digits_q      <= '0;
      dp_q          <= '0;
      frame_valid_q <= 1'b0;
      stale_q       <= 1'b1;
      seg_err_q     <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      an_meta_q     <= an;
      an_sync_q     <= an_meta_q;
      an_smp_q      <= an_sync_q;
      seg_meta_q    <= seg;
      seg_sync_q    <= seg_meta_q;
      seg_smp_q     <= seg_sync_q;
      state_q       <= state_d;
      stab_q        <= stab_d;
      cand_an_q     <= cand_an_d;
      cand_seg_q    <= cand_seg_d;
      digit_sh_q    <= digit_sh_d;
      dp_sh_q       <= dp_sh_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      frame_valid_q <= frame_valid_d;
      stale_q       <= stale_d;
      seg_err_q     <= seg_err_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

`ifdef SEG_DECODE_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_cnt_q <= 8'h00;
    end else if (seg_err_d && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

  assign digits_out  = digits_q;
  assign dp_out      = dp_q;
  assign frame_valid = frame_valid_q;
  assign stale       = stale_q;
  assign seg_err     = seg_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full-scan vectors plus timeout/reset sequences.
module tb_seg_scan_decoder;

  localparam int unsigned TO = 600;
`ifdef SEG_DECODE_ERR_CNT_EN
  localparam logic [7:0] ERR_ONE = 8'd1;
`else
  localparam logic [7:0] ERR_ONE = 8'd0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  an, seg;
  logic [31:0] digits_out;
  logic [7:0]  dp_out, err_count;
  logic        frame_valid, stale, seg_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .STABLE_CYCLES (16),
    .TIMEOUT_CYCLES(TO),
    .DIGIT_MASK    (8'hFC)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .an         (an),
    .seg        (seg),
    .digits_out (digits_out),
    .dp_out     (dp_out),
    .frame_valid(frame_valid),
    .stale      (stale),
    .seg_err    (seg_err),
    .err_count  (err_count)
  );

  typedef struct {
    string       name;
    logic [47:0] raw;       // byte k = seg pattern shown at anode k+2
    int          dwell;
    bit          blank;
    int          exp_frames;
    int          exp_errs;
    logic [31:0] exp_digits;
    logic [7:0]  exp_dp;
    logic        exp_stale;
    logic [7:0]  exp_err_cnt;
  } vec_t;

  vec_t tv [4];
  int checks = 0;
  int errors = 0;
  int n_frames = 0;
  int n_errs = 0;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) n_frames++;
    if (seg_err === 1'b1) n_errs++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    an  = 8'hFF;
    seg = 8'hFF;
    repeat (2) @(negedge clk);
    clr      = 1'b0;
    n_frames = 0;
    n_errs   = 0;
  endtask

  task automatic scan(input logic [47:0] raw, input int dwell, input bit blank, input int first);
    for (int k = first; k < 6; k++) begin
      for (int c = 0; c < dwell; c++) begin
        @(negedge clk);
        an  = ~(8'h01 << (k + 2));
        seg = (blank && (c % 4) != 0) ? 8'hFF : raw[8*k +: 8];
      end
    end
    @(negedge clk);
    an  = 8'hFF;
    seg = 8'hFF;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    tv[0] = '{name: "scan123456", raw: 48'h82_12_19_B0_A4_F9, dwell: 100, blank: 1'b0,
              exp_frames: 1, exp_errs: 0, exp_digits: 32'h6543_2100, exp_dp: 8'h60,
              exp_stale: 1'b0, exp_err_cnt: 8'h00};
    tv[1] = '{name: "blanked", raw: 48'h82_12_19_B0_A4_F9, dwell: 100, blank: 1'b1,
              exp_frames: 1, exp_errs: 0, exp_digits: 32'h6543_2100, exp_dp: 8'h60,
              exp_stale: 1'b0, exp_err_cnt: 8'h00};
    tv[2] = '{name: "short_dwell", raw: 48'h82_12_19_B0_A4_F9, dwell: 10, blank: 1'b0,
              exp_frames: 0, exp_errs: 0, exp_digits: 32'h0, exp_dp: 8'h00,
              exp_stale: 1'b1, exp_err_cnt: 8'h00};
    tv[3] = '{name: "bad_pattern", raw: 48'h82_12_19_B0_A4_FE, dwell: 100, blank: 1'b0,
              exp_frames: 1, exp_errs: 1, exp_digits: 32'h6543_2F00, exp_dp: 8'h60,
              exp_stale: 1'b0, exp_err_cnt: ERR_ONE};

    clr = 1'b1;
    an  = 8'hFF;
    seg = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_digits", digits_out, 32'h0);
    check("rst_dp", {24'h0, dp_out}, 32'h0);
    check("rst_stale", {31'h0, stale}, 32'h1);
    check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_err_count", {24'h0, err_count}, 32'h0);
    clr = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_reset();
      scan(tv[i].raw, tv[i].dwell, tv[i].blank, 0);
      check({tv[i].name, "_frames"}, n_frames, tv[i].exp_frames);
      check({tv[i].name, "_seg_errs"}, n_errs, tv[i].exp_errs);
      check({tv[i].name, "_digits"}, digits_out, tv[i].exp_digits);
      check({tv[i].name, "_dp"}, {24'h0, dp_out}, {24'h0, tv[i].exp_dp});
      check({tv[i].name, "_stale"}, {31'h0, stale}, {31'h0, tv[i].exp_stale});
      check({tv[i].name, "_err_count"}, {24'h0, err_count}, {24'h0, tv[i].exp_err_cnt});
    end

    // Two anodes low: never a valid sample, then a single valid anode must still capture
    do_reset();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      an  = 8'hF3;
      seg = 8'hF9;
    end
    check("multi_an_seen", {24'h0, dut.seen_q}, 32'h0);
    check("multi_an_frames", n_frames, 0);
    check("multi_an_seg_errs", n_errs, 0);
    an = 8'hFB;
    repeat (30) @(negedge clk);
    check("recover_seen", {24'h0, dut.seen_q}, 32'h04);
    an = 8'hFF;

    // Timeout after a complete frame keeps the last digits
    do_reset();
    scan(tv[0].raw, 100, 1'b0, 0);
    check("to_frames", n_frames, 1);
    repeat (300) @(negedge clk);
    check("to_stale_before", {31'h0, stale}, 32'h0);
    repeat (400) @(negedge clk);
    check("to_stale_after", {31'h0, stale}, 32'h1);
    check("to_digits_kept", digits_out, 32'h6543_2100);
    check("to_dp_kept", {24'h0, dp_out}, 32'h60);

    // clr mid-scan discards the partial frame
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      an  = 8'hFB;
      seg = 8'hF9;
    end
    check("mid_seen_pre_clr", {24'h0, dut.seen_q}, 32'h04);
    clr = 1'b1;
    @(negedge clk);
    check("clr_digits", digits_out, 32'h0);
    check("clr_dp", {24'h0, dp_out}, 32'h0);
    check("clr_stale", {31'h0, stale}, 32'h1);
    check("clr_frame_valid", {31'h0, frame_valid}, 32'h0);
    check("clr_seg_err", {31'h0, seg_err}, 32'h0);
    check("clr_seen", {24'h0, dut.seen_q}, 32'h0);
    clr      = 1'b0;
    n_frames = 0;
    scan(tv[0].raw, 100, 1'b0, 1);
    check("partial_frames", n_frames, 0);
    check("partial_stale", {31'h0, stale}, 32'h1);
    check("partial_seen", {24'h0, dut.seen_q}, 32'hF8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
